// File: rtl/vector_mem_unit_if.sv
// Single-port synchronous data-memory bus between vector_mem_unit (master)
// and the data memory (slave). Read data is valid the cycle after mem_re_o.
interface vector_mem_unit_if #(
  parameter int N = 32
);
  logic [N-1:0] mem_addr_o;
  logic         mem_we_o;
  logic         mem_re_o;
  logic [N-1:0] mem_wdata_o;
  logic [N-1:0] mem_rdata_i;

  modport master (
    output mem_addr_o, mem_we_o, mem_re_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_addr_o, mem_we_o, mem_re_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/vector_mem_unit.sv
// MEM-stage access unit: serialises scalar/vector loads and stores onto a
// one-port memory and stalls EX/MEM until done. Optional VMEM_STRIDE_EN macro.
module vector_mem_unit #(
  parameter int N = 32,
  parameter int V = 20
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                valid_i,
  input  logic                OpSource_i,
  input  logic                MemWE_i,
  input  logic                WBSelect_i,
  input  logic [N-1:0]        AluResult_S_i,
  input  logic [N-1:0]        RD1_S_i,
  input  logic [N-1:0]        RD2_S_i,
  input  logic [V-1:0][N-1:0] RD2_V_i,
  output logic                stall_o,
  output logic [N-1:0]        Load_S_o,
  output logic [V-1:0][N-1:0] Load_V_o,
  vector_mem_unit_if.master   mem
);

  localparam int KW = (V > 1) ? $clog2(V) : 1;
  typedef logic [KW-1:0] lane_t;
  localparam lane_t LAST = lane_t'(V - 1);

  typedef enum logic [2:0] {
    IDLE,
    S_LOAD,
    V_STORE,
    V_LOAD,
    V_DRAIN,
    DONE
  } state_e;

  state_e               state_q, state_d;
  lane_t                k_q, k_d;
  lane_t                idx_q, idx_d;
  logic                 inflight_q, inflight_d;
  logic [N-1:0]         base_q, base_d;
  logic [V-1:0][N-1:0]  data_q, data_d;
  logic [V-1:0][N-1:0]  load_v_q, load_v_d;
  logic [N-1:0]         stride;
  logic [N-1:0]         lane_addr;
  logic                 is_store, is_load;

  logic                 stall;
  logic                 we, re;
  logic [N-1:0]         addr, wdata, load_s;

`ifdef VMEM_STRIDE_EN
  logic [N-1:0] stride_q, stride_d;
  assign stride = stride_q;
`else
  logic unused_stride;
  assign stride        = N'(4);
  assign unused_stride = ^RD1_S_i;
`endif

  // Store wins over load when both decode bits are set.
  assign is_store  = valid_i & MemWE_i;
  assign is_load   = valid_i & ~MemWE_i & WBSelect_i;
  assign lane_addr = base_q + stride * N'(k_q);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    k_d        = k_q;
    idx_d      = idx_q;
    inflight_d = 1'b0;
    base_d     = base_q;
    data_d     = data_q;
    load_v_d   = load_v_q;
`ifdef VMEM_STRIDE_EN
    stride_d   = stride_q;
`endif
    stall  = 1'b0;
    we     = 1'b0;
    re     = 1'b0;
    addr   = '0;
    wdata  = '0;
    load_s = '0;

    // Read data for the lane issued last cycle lands in its buffer slot.
    if (inflight_q) load_v_d[idx_q] = mem.mem_rdata_i;

    unique case (state_q)
      IDLE: begin
        if (is_store || is_load) begin
          if (OpSource_i) begin
            stall   = 1'b1;
            base_d  = AluResult_S_i;
            data_d  = RD2_V_i;
`ifdef VMEM_STRIDE_EN
            stride_d = RD1_S_i;
`endif
            k_d     = '0;
            state_d = is_store ? V_STORE : V_LOAD;
          end else if (is_store) begin
            we    = 1'b1;
            addr  = AluResult_S_i;
            wdata = RD2_S_i;
          end else begin
            re      = 1'b1;
            addr    = AluResult_S_i;
            stall   = 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        load_s  = mem.mem_rdata_i;
        state_d = IDLE;
      end
      V_STORE: begin
        stall = 1'b1;
        we    = 1'b1;
        addr  = lane_addr;
        wdata = data_q[k_q];
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + lane_t'(1);
        end
      end
      V_LOAD: begin
        stall      = 1'b1;
        re         = 1'b1;
        addr       = lane_addr;
        idx_d      = k_q;
        inflight_d = 1'b1;
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = V_DRAIN;
        end else begin
          k_d = k_q + lane_t'(1);
        end
      end
      V_DRAIN: begin
        stall   = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Reset silences the combinational IDLE paths immediately as well.
    if (!RST) begin
      stall  = 1'b0;
      we     = 1'b0;
      re     = 1'b0;
      addr   = '0;
      wdata  = '0;
      load_s = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: the operand and load buffers are reset too; a freshly reset unit
    // must present Load_V_o = 0, so these are flops, not an inferred RAM.
    if (!RST) begin
      state_q    <= IDLE;
      k_q        <= '0;
      idx_q      <= '0;
      inflight_q <= 1'b0;
      base_q     <= '0;
      data_q     <= '0;
      load_v_q   <= '0;
`ifdef VMEM_STRIDE_EN
      stride_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q    <= state_d;
      k_q        <= k_d;
      idx_q      <= idx_d;
      inflight_q <= inflight_d;
      base_q     <= base_d;
      data_q     <= data_d;
      load_v_q   <= load_v_d;
`ifdef VMEM_STRIDE_EN
      stride_q   <= stride_d;
`endif
    end
  end

  assign stall_o         = stall;
  assign Load_S_o        = load_s;
  assign Load_V_o        = load_v_q;
  assign mem.mem_addr_o  = addr;
  assign mem.mem_we_o    = we;
  assign mem.mem_re_o    = re;
  assign mem.mem_wdata_o = wdata;

endmodule

// File: tb/tb_vector_mem_unit.sv
// Self-checking bench for vector_mem_unit: directed cases plus $urandom ops,
// checked against a word-addressed reference memory kept in the bench.
module tb_vector_mem_unit;
  localparam int N = 32;
  localparam int V = 20;

  logic                CLK = 1'b0;
  logic                RST = 1'b0;
  logic                valid_i, OpSource_i, MemWE_i, WBSelect_i;
  logic [N-1:0]        AluResult_S_i, RD1_S_i, RD2_S_i;
  logic [V-1:0][N-1:0] RD2_V_i;
  logic                stall_o;
  logic [N-1:0]        Load_S_o;
  logic [V-1:0][N-1:0] Load_V_o;

  vector_mem_unit_if #(.N(N)) bus ();

  vector_mem_unit #(.N(N), .V(V)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .valid_i       (valid_i),
    .OpSource_i    (OpSource_i),
    .MemWE_i       (MemWE_i),
    .WBSelect_i    (WBSelect_i),
    .AluResult_S_i (AluResult_S_i),
    .RD1_S_i       (RD1_S_i),
    .RD2_S_i       (RD2_S_i),
    .RD2_V_i       (RD2_V_i),
    .stall_o       (stall_o),
    .Load_S_o      (Load_S_o),
    .Load_V_o      (Load_V_o),
    .mem           (bus)
  );

  always #5 CLK = ~CLK;

  // Data memory the DUT talks to.
  logic [N-1:0] ram [bit [N-1:0]];
  initial bus.mem_rdata_i = '0;
  always @(posedge CLK) begin
    if (bus.mem_we_o) ram[bus.mem_addr_o] = bus.mem_wdata_o;
    if (bus.mem_re_o)
      bus.mem_rdata_i <= ram.exists(bus.mem_addr_o) ? ram[bus.mem_addr_o] : '0;
  end

  // Reference model: what memory should hold if every access went where it should.
  logic [N-1:0] ref_mem [bit [N-1:0]];
  logic [N-1:0] obs_addr [V];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_rd(input logic [N-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic logic [N-1:0] eff_stride(input logic [N-1:0] s);
`ifdef VMEM_STRIDE_EN
    return s;
`else
    return 32'd4;
`endif
  endfunction

  task automatic idle_inputs();
    valid_i    = 1'b0;
    OpSource_i = 1'b0;
    MemWE_i    = 1'b0;
    WBSelect_i = 1'b0;
  endtask

  task automatic scramble();
    AluResult_S_i = $urandom;
    RD1_S_i       = $urandom;
    RD2_S_i       = $urandom;
    for (int k = 0; k < V; k++) RD2_V_i[k] = $urandom;
  endtask

  task automatic vec_op(input bit st, input logic [N-1:0] base, input logic [N-1:0] stride,
                        input logic [V-1:0][N-1:0] data);
    logic [N-1:0] es, a;
    int last;
    @(posedge CLK); #1;
    valid_i = 1'b1; OpSource_i = 1'b1; MemWE_i = st;
    WBSelect_i = st ? 1'($urandom_range(0, 1)) : 1'b1;
    AluResult_S_i = base; RD1_S_i = stride; RD2_V_i = data; RD2_S_i = $urandom;
    es   = eff_stride(stride);
    last = st ? V + 1 : V + 2;
    for (int c = 0; c <= last; c++) begin
      @(negedge CLK);
      check("stall", stall_o, (c < last));
      if (c >= 1 && c <= V) begin
        a = base + es * (c - 1);
        obs_addr[c-1] = bus.mem_addr_o;
        check("lane_addr", bus.mem_addr_o, a);
        check("we", bus.mem_we_o, st);
        check("re", bus.mem_re_o, !st);
        if (st) begin
          check("wdata", bus.mem_wdata_o, data[c-1]);
          ref_mem[a] = data[c-1];
        end
      end else begin
        check("no_we", bus.mem_we_o, 1'b0);
        check("no_re", bus.mem_re_o, 1'b0);
      end
      if (c == last && !st)
        for (int k = 0; k < V; k++) check("load_v", Load_V_o[k], ref_rd(base + es * k));
      @(posedge CLK); #1;
      if (c < last) begin
        scramble();
        valid_i = 1'($urandom_range(0, 1));
      end
    end
    idle_inputs();
  endtask

  task automatic s_store(input logic [N-1:0] a, input logic [N-1:0] d);
    @(posedge CLK); #1;
    valid_i = 1'b1; OpSource_i = 1'b0; MemWE_i = 1'b1; WBSelect_i = 1'($urandom_range(0, 1));
    AluResult_S_i = a; RD2_S_i = d; RD1_S_i = $urandom;
    @(negedge CLK);
    check("ss_stall", stall_o, 1'b0);
    check("ss_we", bus.mem_we_o, 1'b1);
    check("ss_re", bus.mem_re_o, 1'b0);
    check("ss_addr", bus.mem_addr_o, a);
    check("ss_wdata", bus.mem_wdata_o, d);
    ref_mem[a] = d;
    @(posedge CLK); #1;
    idle_inputs();
  endtask

  task automatic s_load(input logic [N-1:0] a);
    @(posedge CLK); #1;
    valid_i = 1'b1; OpSource_i = 1'b0; MemWE_i = 1'b0; WBSelect_i = 1'b1;
    AluResult_S_i = a; RD2_S_i = $urandom;
    @(negedge CLK);
    check("sl_stall0", stall_o, 1'b1);
    check("sl_re", bus.mem_re_o, 1'b1);
    check("sl_we", bus.mem_we_o, 1'b0);
    check("sl_addr", bus.mem_addr_o, a);
    @(negedge CLK);
    check("sl_stall1", stall_o, 1'b0);
    check("sl_data", Load_S_o, ref_rd(a));
    @(posedge CLK); #1;
    idle_inputs();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_stall"}, stall_o, 1'b0);
    check({tag, "_we"}, bus.mem_we_o, 1'b0);
    check({tag, "_re"}, bus.mem_re_o, 1'b0);
    check({tag, "_addr"}, bus.mem_addr_o, '0);
    check({tag, "_wdata"}, bus.mem_wdata_o, '0);
    check({tag, "_loads"}, Load_S_o, '0);
    for (int k = 0; k < V; k++) check({tag, "_loadv"}, Load_V_o[k], '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [V-1:0][N-1:0] d;
    logic [N-1:0] a;

    // Reset with a live scalar store on the inputs: everything must stay quiet.
    scramble();
    valid_i = 1'b1; OpSource_i = 1'b0; MemWE_i = 1'b1; WBSelect_i = 1'b0;
    #3;
    check_outputs_zero("rst");
    idle_inputs();
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // Vector store, base 0x100, lane k = 0x10+k.
    for (int k = 0; k < V; k++) d[k] = 32'h10 + k;
    vec_op(1'b1, 32'h100, 32'd4, d);

    // Vector load from a preloaded region.
    for (int k = 0; k < V; k++) begin
      ram[32'h200 + 4 * k]     = 32'hA000 + k;
      ref_mem[32'h200 + 4 * k] = 32'hA000 + k;
    end
    vec_op(1'b0, 32'h200, 32'd4, d);

    // Scalar store then scalar load of the same word.
    s_store(32'h40, 32'h55);
    s_load(32'h40);

    // Decoded no-op passes straight through.
    @(posedge CLK); #1;
    valid_i = 1'b1; OpSource_i = 1'($urandom_range(0, 1)); MemWE_i = 1'b0; WBSelect_i = 1'b0;
    @(negedge CLK);
    check("nop_stall", stall_o, 1'b0);
    check("nop_we", bus.mem_we_o, 1'b0);
    check("nop_re", bus.mem_re_o, 1'b0);
    @(posedge CLK); #1;
    idle_inputs();

    // Address wrap at the top of the space.
    for (int k = 0; k < V; k++) d[k] = $urandom;
    vec_op(1'b1, 32'hFFFF_FFF8, 32'd4, d);
    check("wrap_lane2", obs_addr[2], 32'h0);
    check("wrap_lane3", obs_addr[3], 32'h4);

    // Stride of 8 from base 0 (fixed 4 unless the stride feature is built in).
    vec_op(1'b0, 32'h0, 32'd8, d);
    check("stride_lane1", obs_addr[1], eff_stride(32'd8));
    check("stride_lane2", obs_addr[2], 2 * eff_stride(32'd8));

    // Reset during cycle 6 of a vector store: only lanes 0..4 reach memory.
    for (int k = 0; k < V; k++) d[k] = 32'hC000 + k;
    @(posedge CLK); #1;
    valid_i = 1'b1; OpSource_i = 1'b1; MemWE_i = 1'b1; WBSelect_i = 1'b0;
    AluResult_S_i = 32'h3000; RD1_S_i = 32'd4; RD2_V_i = d;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      check("rv_stall", stall_o, 1'b1);
      check("rv_we", bus.mem_we_o, (c >= 1));
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    #1;
    check_outputs_zero("rv");
    idle_inputs();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a = 32'h3000 + 4 * k;
      check("rv_written", 32'(ram.exists(a)), 32'(k < 5));
      if (k < 5) begin
        check("rv_data", ram[a], 32'hC000 + k);
        ref_mem[a] = 32'hC000 + k;
      end
    end
    for (int k = 0; k < V; k++) d[k] = $urandom;
    vec_op(1'b1, 32'h3100, 32'd4, d);
    vec_op(1'b0, 32'h3100, 32'd4, d);

    // Randomised mix over a small shared region so loads see earlier stores.
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: s_store(32'h1000 + ($urandom_range(0, 31) << 2), $urandom);
        1: s_load(32'h1000 + ($urandom_range(0, 31) << 2));
        2: begin
          for (int k = 0; k < V; k++) d[k] = $urandom;
          vec_op(1'b1, 32'h1000 + ($urandom_range(0, 15) << 2), $urandom_range(0, 4) << 2, d);
        end
        default: vec_op(1'b0, 32'h1000 + ($urandom_range(0, 15) << 2),
                        $urandom_range(0, 4) << 2, d);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
